// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle, with single-cycle bypass for divide-by-zero and signed overflow.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output logic            reg_write
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
   localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [2:0]      f3_q, f3_d;
   logic            neg_q, neg_d;
   logic [XLEN-1:0] opd_q, opd_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;
   logic            reg_write_q, reg_write_d;

   // Operand decode at accept: signedness, magnitudes and bypass cases.
   logic            is_div_s, a_signed_s, b_signed_s, a_neg_s, b_neg_s;
   logic [XLEN-1:0] a_mag_s, b_mag_s, special_res_s;
   logic            div_zero_s, ovf_s, special_s;

   always_comb begin
      is_div_s      = funct3[2];
      a_signed_s    = is_div_s ? ~funct3[0] : (funct3[1:0] != 2'b11);
      b_signed_s    = is_div_s ? ~funct3[0] : ~funct3[1];
      a_neg_s       = a_signed_s & op_a[XLEN-1];
      b_neg_s       = b_signed_s & op_b[XLEN-1];
      a_mag_s       = a_neg_s ? (ZERO - op_a) : op_a;
      b_mag_s       = b_neg_s ? (ZERO - op_b) : op_b;
      div_zero_s    = is_div_s && (op_b == ZERO);
      ovf_s         = is_div_s && !funct3[0] && (op_a == MIN_INT) && (op_b == ALL_ONES);
      special_s     = div_zero_s || ovf_s;
      if (div_zero_s) begin
         special_res_s = funct3[1] ? op_a : ALL_ONES;
      end else begin
         special_res_s = funct3[1] ? ZERO : MIN_INT;
      end
   end

   // Iteration datapath and final sign fix-up / result selection.
   logic [XLEN:0]     mul_sum_s, rem_shift_s;
   logic              rem_ge_s;
   logic [XLEN-1:0]   rem_sub_s, quo_fix_s, rem_fix_s, fix_res_s;
   logic [2*XLEN-1:0] prod_fix_s;

   always_comb begin
      mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : {(XLEN+1){1'b0}});
      rem_shift_s = {hi_q, lo_q[XLEN-1]};
      rem_ge_s    = rem_shift_s >= {1'b0, opd_q};
      rem_sub_s   = rem_shift_s[XLEN-1:0] - opd_q;
      prod_fix_s  = neg_q ? ({(2*XLEN){1'b0}} - {hi_q, lo_q}) : {hi_q, lo_q};
      quo_fix_s   = neg_q ? (ZERO - lo_q) : lo_q;
      rem_fix_s   = neg_q ? (ZERO - hi_q) : hi_q;
      case (f3_q)
         3'b000:                 fix_res_s = prod_fix_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fix_res_s = quo_fix_s;
         3'b110, 3'b111:         fix_res_s = rem_fix_s;
         default:                fix_res_s = ZERO;
      endcase
   end

   // Next-state logic; flush beats start, and DONE always returns to IDLE.
   always_comb begin
      state_d     = state_q;
      f3_d        = f3_q;
      neg_d       = neg_q;
      opd_d       = opd_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      cnt_d       = cnt_q;
      rd_d        = rd_q;
      result_d    = result_q;
      done_d      = 1'b0;
      busy_d      = busy_q;
      reg_write_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               f3_d   = funct3;
               rd_d   = rd_in;
               cnt_d  = {CW{1'b0}};
               hi_d   = ZERO;
               busy_d = 1'b1;
               if (is_div_s) begin
                  opd_d = b_mag_s;
                  lo_d  = a_mag_s;
                  neg_d = funct3[1] ? a_neg_s : (a_neg_s ^ b_neg_s);
               end else begin
                  opd_d = a_mag_s;
                  lo_d  = b_mag_s;
                  neg_d = a_neg_s ^ b_neg_s;
               end
               if (special_s) begin
                  state_d     = S_DONE;
                  result_d    = special_res_s;
                  done_d      = 1'b1;
                  reg_write_d = (rd_in != 5'd0);
               end else begin
                  state_d = S_CALC;
               end
            end else begin
               busy_d = 1'b0;
            end
         end
         S_CALC: begin
            if (flush) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               if (f3_q[2]) begin
                  hi_d = rem_ge_s ? rem_sub_s : rem_shift_s[XLEN-1:0];
                  lo_d = {lo_q[XLEN-2:0], rem_ge_s};
               end else begin
                  hi_d = mul_sum_s[XLEN:1];
                  lo_d = {mul_sum_s[0], lo_q[XLEN-1:1]};
               end
               if (cnt_q == CNT_LAST) begin
                  state_d = S_FIX;
               end else begin
                  cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
               end
            end
         end
         S_FIX: begin
            if (flush) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               state_d     = S_DONE;
               result_d    = fix_res_s;
               done_d      = 1'b1;
               reg_write_d = (rd_q != 5'd0);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         f3_q        <= 3'b000;
         neg_q       <= 1'b0;
         opd_q       <= ZERO;
         hi_q        <= ZERO;
         lo_q        <= ZERO;
         cnt_q       <= {CW{1'b0}};
         rd_q        <= 5'd0;
         result_q    <= ZERO;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         reg_write_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         f3_q        <= f3_d;
         neg_q       <= neg_d;
         opd_q       <= opd_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         cnt_q       <= cnt_d;
         rd_q        <= rd_d;
         result_q    <= result_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         reg_write_q <= reg_write_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign rd_out    = rd_q;
   assign reg_write = reg_write_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results computed
// with plain 64-bit arithmetic; a negedge monitor pops and compares on done.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] op_a = 32'd0;
   logic [31:0] op_b = 32'd0;
   logic [4:0]  rd_in = 5'd0;
   logic        busy, done, reg_write;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        rw;
      int          cyc;
   } exp_t;
   exp_t scb[$];

   muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .flush(flush),
      .funct3(funct3), .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
      .busy(busy), .done(done), .result(result), .rd_out(rd_out),
      .reg_write(reg_write)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sbv = longint'($signed(b));
      longint ua = longint'({32'd0, a});
      longint ub = longint'({32'd0, b});
      logic [63:0] p;
      case (f3)
         3'd0: begin p = sa * sbv; return p[31:0]; end
         3'd1: begin p = sa * sbv; return p[63:32]; end
         3'd2: begin p = sa * ub;  return p[63:32]; end
         3'd3: begin p = ua * ub;  return p[63:32]; end
         3'd4: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = sa / sbv; return p[31:0]; end
         3'd5: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = ua / ub;  return p[31:0]; end
         3'd6: begin if (b == 32'd0) return a; p = sa % sbv; return p[31:0]; end
         default: begin if (b == 32'd0) return a; p = ua % ub; return p[31:0]; end
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
      return (f3[2] && b == 32'd0) ||
             ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // Monitor: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (reset_n && done) begin
         checks++;
         if (scb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done result=%h rd_out=%0d", result, rd_out);
         end else begin
            exp_t e;
            e = scb.pop_front();
            if (result !== e.res || rd_out !== e.rd || reg_write !== e.rw ||
                cyc !== e.cyc || busy !== 1'b1) begin
               errors++;
               $display("FAIL done_cmp got res=%h rd=%0d rw=%b cyc=%0d busy=%b exp res=%h rd=%0d rw=%b cyc=%0d busy=1",
                        result, rd_out, reg_write, cyc, busy, e.res, e.rd, e.rw, e.cyc);
            end
         end
      end else if (reset_n && reg_write) begin
         checks++;
         errors++;
         $display("FAIL reg_write_without_done got 1 exp 0");
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", name, got, exp);
      end
   endtask

   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit expect_done);
      exp_t e;
      @(negedge clk);
      funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
      if (expect_done) begin
         e.res = ref_model(f3, a, b);
         e.rd  = rd;
         e.rw  = (rd != 5'd0);
         e.cyc = cyc + (is_special(f3, a, b) ? 1 : 34);
         scb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom_range(7, 0));
   endtask

   task automatic drain();
      int n = 0;
      while (scb.size() != 0 && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      if (scb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout pending=%0d exp 0", scb.size());
         scb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_outputs_zero(input string name);
      check(name, {busy, done, reg_write, rd_out, result}, 40'd0);
   endtask

   logic [31:0] ra, rb;

   initial begin
      #1 check_outputs_zero("reset_state");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      issue(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 1'b1); drain();
      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b1); drain();
      issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1); drain();
      issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1); drain();
      issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1); drain();
      issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1); drain();
      issue(3'd5, 32'd100, 32'd7, 5'd7, 1'b1); drain();
      issue(3'd7, 32'd100, 32'd7, 5'd8, 1'b1); drain();
      issue(3'd4, 32'h0000_1234, 32'd0, 5'd9, 1'b1); drain();
      issue(3'd6, 32'h1234_5678, 32'd0, 5'd10, 1'b1); drain();
      issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b1); drain();
      issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1); drain();
      issue(3'd0, 32'd3, 32'd5, 5'd0, 1'b1); drain();

      // Second start while busy must be ignored.
      issue(3'd0, 32'd11, 32'd13, 5'd14, 1'b1);
      repeat (5) @(negedge clk);
      start = 1'b1; funct3 = 3'd5; op_a = 32'd99; op_b = 32'd9; rd_in = 5'd15;
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (40) @(negedge clk);

      // start held during the DONE cycle is not accepted.
      issue(3'd5, 32'd5, 32'd0, 5'd16, 1'b1);
      start = 1'b1; funct3 = 3'd0; op_a = 32'd2; op_b = 32'd3; rd_in = 5'd17;
      @(negedge clk);
      start = 1'b0;
      check("start_in_done_busy", {31'd0, busy}, 32'd0);
      repeat (40) @(negedge clk);

      // flush and start together in IDLE: nothing accepted.
      @(negedge clk);
      start = 1'b1; flush = 1'b1; funct3 = 3'd0; op_a = 32'd4; op_b = 32'd4; rd_in = 5'd3;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_start_idle_busy", {31'd0, busy}, 32'd0);
      repeat (40) @(negedge clk);

      // Flush during CALC.
      issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd18, 1'b0);
      repeat (9) @(negedge clk);
      check("busy_before_flush", {31'd0, busy}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("busy_after_flush", {31'd0, busy}, 32'd0);
      repeat (40) @(negedge clk);
      issue(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd19, 1'b1); drain();

      // Asynchronous reset during CALC.
      issue(3'd6, 32'h7FFF_FFFF, 32'd3, 5'd20, 1'b0);
      repeat (19) @(negedge clk);
      #2 reset_n = 1'b0;
      #1 check_outputs_zero("reset_mid_op");
      @(negedge clk);
      #2 reset_n = 1'b1;
      repeat (40) @(negedge clk);
      issue(3'd7, 32'hDEAD_BEEF, 32'h0000_1000, 5'd21, 1'b1); drain();

      // Randomized operations with corner-value bias.
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(5, 0))
            0: ra = 32'h8000_0000;
            1: ra = 32'hFFFF_FFFF;
            2: ra = 32'($urandom_range(20, 0));
            default: ra = $urandom;
         endcase
         case ($urandom_range(5, 0))
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            2: rb = 32'($urandom_range(20, 1));
            default: rb = $urandom;
         endcase
         issue(3'($urandom_range(7, 0)), ra, rb, 5'($urandom_range(31, 0)), 1'b1);
         drain();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
